// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and memory-macro signals of mem_port_arbiter.
// master: the arbiter's view; slave: the core/memory side.
interface mem_port_arbiter_if #(
  parameter int N = 1024
);
  localparam int AW = $clog2(N);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and load/store ports, fixed read latency.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is data-port priority.
module mem_port_arbiter #(
  parameter int N       = 1024,
  parameter int MEM_LAT = 1
) (
  input  logic                CLK,
  input  logic                RST,
  mem_port_arbiter_if.master  bus,
  output logic                busy
);
  localparam int AW = $clog2(N);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT=%0d outside 1..4", MEM_LAT);
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cnt;
  logic          grant_d, grant_d_nxt;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   d_rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          last_d;

  always_comb begin
    grant_d_nxt = bus.d_req;
    if (bus.d_req && bus.if_req) grant_d_nxt = ~last_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                             last_d <= 1'b0;
    else if (state == IDLE && (bus.if_req || bus.d_req)) last_d <= grant_d_nxt;
  end
`else
  always_comb begin
    grant_d_nxt = bus.d_req;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.if_req || bus.d_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 3'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is latched in IDLE so mem_addr/mem_wdata stay stable through RESP
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      grant_d    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.if_req || bus.d_req) begin
          grant_d <= grant_d_nxt;
          addr_q  <= grant_d_nxt ? bus.d_addr : bus.if_addr;
          we_q    <= grant_d_nxt & bus.d_we;
          wdata_q <= bus.d_wdata;
        end
        ISSUE: cnt <= 3'(MEM_LAT);
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1 && !we_q) begin
            if (grant_d) d_rdata_q  <= bus.mem_rdata;
            else         if_rdata_q <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_en = (state == ISSUE);
    bus.mem_we = (state == ISSUE) && we_q;
    bus.if_ack = (state == RESP) && !grant_d;
    bus.d_ack  = (state == RESP) && grant_d;
    busy       = (state != IDLE);
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule
